action_sched: RTL
=================

ACTION_SCHED -- requirements
Module: action_sched

Interface
REQ-001 SHALL have parameter ACTION_W, default 64, the width of one action word.
REQ-002 SHALL have parameter NUM_REQ, default 4, the number of requesters (2..8).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, the drain-wait watchdog limit in cycles (only used when ACTION_SCHED_TIMEOUT_EN is defined).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits: per-requester action pending.
REQ-007 SHALL have port req_action, input, NUM_REQ*ACTION_W bits: per-requester action, requester i in slice [i*ACTION_W +: ACTION_W].
REQ-008 SHALL have port req_ready, output, NUM_REQ bits: one-hot grant pulse; the action is accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port req_done, output, NUM_REQ bits: one-hot 1-cycle completion pulse to the granted requester.
REQ-010 SHALL have port pkt_start, output, 1 bit: 1-cycle packet-start pulse to the drain controller.
REQ-011 SHALL have port action_valid, output, 1 bit: 1-cycle action-valid pulse to the drain controller.
REQ-012 SHALL have port action_out, output, ACTION_W bits: the latched action of the current grant.
REQ-013 SHALL have port allow_drain, input, 1 bit: drain permission returned by the drain controller.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port timeout, output, 1 bit: 1-cycle watchdog-expiry pulse.

Function
REQ-016 SHALL implement the FSM IDLE -> GRANT -> PKT -> ACT -> WAIT -> DONE -> IDLE, taking exactly one cycle per state except WAIT.
REQ-017 In IDLE, when any req_valid bit is set, SHALL select the winner round-robin, starting the search at index (last_grant+1) mod NUM_REQ, and move to GRANT.
REQ-018 In GRANT, SHALL assert req_ready[winner] for exactly 1 cycle, latch req_action[winner] into action_out, and record the winner index.
REQ-019 If req_valid[winner] has dropped by the GRANT cycle, SHALL return to IDLE without latching, leaving the round-robin pointer unchanged.
REQ-020 In PKT, SHALL assert pkt_start for 1 cycle.
REQ-021 In ACT, SHALL assert action_valid for 1 cycle; action_out SHALL be held stable from GRANT+1 until the return to IDLE.
REQ-022 In WAIT, SHALL stay until allow_drain is sampled high, then move to DONE; an allow_drain already high on WAIT entry SHALL complete WAIT in 1 cycle.
REQ-023 In DONE, SHALL pulse req_done[winner], update last_grant to the winner, and return to IDLE.
REQ-024 allow_drain high outside WAIT SHALL be ignored.
REQ-025 Requester changes in req_valid after GRANT SHALL NOT affect the transaction in progress.
REQ-026 Minimum back-to-back throughput SHALL be one action per 6 cycles.

Reset
REQ-027 Reset SHALL drive the FSM to IDLE, set last_grant to NUM_REQ-1 (so requester 0 wins first), and clear req_ready, req_done, pkt_start, action_valid, action_out, busy, timeout and the watchdog counter to 0.
REQ-028 Reset asserted mid-transaction SHALL abort it with no req_done pulse; after release the block SHALL re-arbitrate from IDLE.

Configuration
REQ-029 With ACTION_SCHED_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-030 With ACTION_SCHED_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYC-1 without allow_drain, the block SHALL pulse timeout for 1 cycle, skip req_done, update last_grant, and return to IDLE.
REQ-031 Without ACTION_SCHED_TIMEOUT_EN, WAIT SHALL be unbounded, timeout SHALL be tied to 0, and no counter SHALL be instantiated.

Structure
REQ-032 The shared package action_pkg SHALL hold the ACTION_W default and the FSM state encoding.
REQ-033 The round-robin winner search SHALL be a separate sub-module, rr_arbiter (combinational: request vector plus pointer in, one-hot grant out).

Verification
REQ-034 A bench SHALL cover single requester: req_valid=4'b0010 with action 64'hDEAD_BEEF_0000_0001, allow_drain high 3 cycles after action_valid -> req_ready[1] at cycle 1, pkt_start at 2, action_valid at 3, req_done[1] at 7.
REQ-035 A bench SHALL cover all requesters continuously valid -> grant order 0,1,2,3,0, each spaced 6 cycles apart when allow_drain is held high.
REQ-036 A bench SHALL cover a request withdrawn before GRANT: req_valid[2] pulsed for 1 cycle -> no pkt_start, FSM back in IDLE, next grant still starts the search from index 2.
REQ-037 A bench SHALL cover reset in WAIT: resetn low for 2 cycles -> all outputs 0, no req_done, requester 0 granted first after release.
REQ-038 A bench SHALL cover the macro-defined build with TIMEOUT_CYC=16 and allow_drain held low -> timeout pulse 16 cycles after WAIT entry, no req_done, next requester granted.
REQ-039 A bench SHALL cover allow_drain pulsed during IDLE and PKT -> ignored, and WAIT still waits for a fresh allow_drain.

Source files
------------

// File: rtl/action_pkg.sv
// Shared definitions for the action scheduler: default action width, FSM state
// encoding and a one-hot to index helper.
package action_pkg;

  localparam int ACTION_W_DEF = 64;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GRANT = 3'd1;
  localparam logic [2:0] ST_PKT   = 3'd2;
  localparam logic [2:0] ST_ACT   = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = idx | (oh[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/action_sched_if.sv
// Requester and drain-controller signal bundle of the action scheduler.
// The scheduler connects through the slave modport.
interface action_sched_if #(
  parameter int NUM_REQ  = 4,
  parameter int ACTION_W = 64
) ();
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*ACTION_W-1:0] req_action;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          req_done;
  logic                        pkt_start;
  logic                        action_valid;
  logic [ACTION_W-1:0]         action_out;
  logic                        allow_drain;
  logic                        busy;
  logic                        timeout;

  modport slave (
    input  req_valid, req_action, allow_drain,
    output req_ready, req_done, pkt_start, action_valid, action_out, busy, timeout
  );

  modport master (
    output req_valid, req_action, allow_drain,
    input  req_ready, req_done, pkt_start, action_valid, action_out, busy, timeout
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search: the lowest set request strictly above
// the pointer wins, otherwise the lowest set request overall (wrap-around).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);
  logic [NUM_REQ-1:0] hi_mask_s;
  logic [NUM_REQ-1:0] masked_s;

  // Isolate the lowest set bit of the masked vector, falling back to the full vector
  always_comb begin
    hi_mask_s = ({NUM_REQ{1'b1}} << ptr) << 1;
    masked_s  = req & hi_mask_s;
    if (masked_s != '0) begin
      grant = masked_s & (~masked_s + {{(NUM_REQ-1){1'b0}}, 1'b1});
    end else begin
      grant = req & (~req + {{(NUM_REQ-1){1'b0}}, 1'b1});
    end
  end
endmodule

// File: rtl/action_sched.sv
// Action scheduler: round-robin grant, latch action, handshake with drain controller.
// Optional drain-wait watchdog enabled by defining ACTION_SCHED_TIMEOUT_EN.
module action_sched
  import action_pkg::*;
#(
  parameter int ACTION_W    = ACTION_W_DEF,
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic           clk,
  input logic           resetn,
  action_sched_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("action_sched: parameter out of range");
  end

  logic [2:0]          state_r;
  logic [2:0]          state_nx_s;
  logic [IDX_W-1:0]    last_grant_r;
  logic [NUM_REQ-1:0]  arb_grant_s;
  logic [NUM_REQ-1:0]  grant_oh_r;
  logic [ACTION_W-1:0] sel_action_s;
  logic [ACTION_W-1:0] action_r;
  logic [NUM_REQ-1:0]  req_ready_r;
  logic [NUM_REQ-1:0]  req_done_r;
  logic                pkt_start_r;
  logic                action_valid_r;
  logic                busy_r;
  logic                timeout_r;
  logic                expire_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (bus.req_valid),
    .ptr   (last_grant_r),
    .grant (arb_grant_s)
  );

`ifdef ACTION_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] wd_cnt_r;

  // Watchdog counter: zero on WAIT entry, counts every WAIT cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt_r <= '0;
    end else if (state_r != ST_WAIT) begin
      wd_cnt_r <= '0;
    end else begin
      wd_cnt_r <= wd_cnt_r + CNT_W'(1);
    end
  end

  assign expire_s = (state_r == ST_WAIT) && !bus.allow_drain &&
                    (wd_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign expire_s = 1'b0;
`endif

  // Next-state logic and action mux for the recorded winner
  always_comb begin
    state_nx_s   = state_r;
    sel_action_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_action_s = sel_action_s |
                     ({ACTION_W{grant_oh_r[i]}} & bus.req_action[i*ACTION_W +: ACTION_W]);
    end
    case (state_r)
      ST_IDLE:  if (|bus.req_valid) state_nx_s = ST_GRANT; else state_nx_s = ST_IDLE;
      ST_GRANT: if (|(bus.req_valid & grant_oh_r)) state_nx_s = ST_PKT; else state_nx_s = ST_IDLE;
      ST_PKT:   state_nx_s = ST_ACT;
      ST_ACT:   state_nx_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.allow_drain)   state_nx_s = ST_DONE;
        else if (expire_s)     state_nx_s = ST_IDLE;
        else                   state_nx_s = ST_WAIT;
      end
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // State, grant bookkeeping and outputs registered from the next state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      last_grant_r   <= IDX_W'(NUM_REQ - 1);
      grant_oh_r     <= '0;
      action_r       <= '0;
      req_ready_r    <= '0;
      req_done_r     <= '0;
      pkt_start_r    <= 1'b0;
      action_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      timeout_r      <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (state_r == ST_IDLE && state_nx_s == ST_GRANT) begin
        grant_oh_r <= arb_grant_s;
      end
      if (state_r == ST_GRANT && state_nx_s == ST_PKT) begin
        action_r <= sel_action_s;
      end
      // A withdrawn request leaves the pointer alone; completion or expiry advances it
      if (state_r == ST_DONE || expire_s) begin
        last_grant_r <= IDX_W'(oh_to_idx(8'(grant_oh_r)));
      end
      req_ready_r    <= (state_nx_s == ST_GRANT) ? arb_grant_s : '0;
      req_done_r     <= (state_nx_s == ST_DONE) ? grant_oh_r : '0;
      pkt_start_r    <= (state_nx_s == ST_PKT);
      action_valid_r <= (state_nx_s == ST_ACT);
      busy_r         <= (state_nx_s != ST_IDLE);
      timeout_r      <= expire_s;
    end
  end

  assign bus.req_ready    = req_ready_r;
  assign bus.req_done     = req_done_r;
  assign bus.pkt_start    = pkt_start_r;
  assign bus.action_valid = action_valid_r;
  assign bus.action_out   = action_r;
  assign bus.busy         = busy_r;
  assign bus.timeout      = timeout_r;
endmodule
